// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seven_seg_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_UNLIT_AL = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g}; listed from F down to 0 so SEG_LUT[n] is hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_lut.sv
// Hex nibble to active-low seven-segment pattern; polarity is applied by the parent.
module seg_hex_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_al_c
);

    assign seg_al_c = SEG_LUT[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment driver with frame-synchronous commit and guard gaps.
// Optional leading-zero suppression: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned GUARD_CYCLES   = 500,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int unsigned DISP_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W  = $clog2(max_u(REFRESH_DIV, GUARD_CYCLES));

    localparam logic [CNT_W-1:0] CNT_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_UNLIT =
        (SEG_ACTIVE_LOW != 0) ? SEG_UNLIT_AL : ~SEG_UNLIT_AL;
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    scan_state_e       state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DISP_W-1:0] shadow, shadow_next;
    logic [DISP_W-1:0] display, display_next;
    logic              pending_next;
    logic              frame_start_next;

    logic [3:0]            nibble_sel;
    logic                  blank_sel;
    logic [NUM_DIGITS-1:0] an_en_sel;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [6:0]            lut_seg_al;
    logic [6:0]            seg_al;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    // State, scan position, data registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= GUARD;
            idx         <= '0;
            cnt         <= '0;
            shadow      <= '0;
            display     <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
            seg_out     <= SEG_UNLIT;
            an_out      <= AN_OFF;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            cnt         <= cnt_next;
            shadow      <= shadow_next;
            display     <= display_next;
            pending     <= pending_next;
            frame_start <= frame_start_next;
            seg_out     <= seg_next;
            an_out      <= an_next;
        end
    end

    // Scan sequencing, frame commit and shadow load.
    always_comb begin
        state_next       = state;
        idx_next         = idx;
        cnt_next         = cnt + CNT_W'(1);
        shadow_next      = shadow;
        display_next     = display;
        pending_next     = pending;
        frame_start_next = 1'b0;

        case (state)
            GUARD: begin
                if (cnt == CNT_GUARD_LAST) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                    if (idx == '0) begin
                        frame_start_next = 1'b1;
                        if (pending) begin
                            display_next = shadow;
                            pending_next = 1'b0;
                        end
                    end
                end
            end
            DRIVE: begin
                if (cnt == CNT_DRIVE_LAST) begin
                    state_next = GUARD;
                    cnt_next   = '0;
                    idx_next   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end
            default: begin
                state_next = GUARD;
                cnt_next   = '0;
            end
        endcase

        // A load on the commit edge still wins the shadow and keeps pending set.
        if (load) begin
            shadow_next  = digits_in;
            pending_next = 1'b1;
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Digit k >= 1 is suppressed while every nibble from k upward is zero.
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            upper_zero  = upper_zero & (display_next[4*k +: 4] == 4'h0);
            lz_blank[k] = upper_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Select the digit that will be driven after this edge.
    always_comb begin
        nibble_sel = 4'h0;
        blank_sel  = 1'b0;
        an_en_sel  = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_next == IDX_W'(k)) begin
                nibble_sel   = display_next[4*k +: 4];
                blank_sel    = blank_mask[k] | lz_blank[k];
                an_en_sel[k] = 1'b1;
            end
        end
    end

    seg_hex_lut u_lut (
        .nibble   (nibble_sel),
        .seg_al_c (lut_seg_al)
    );

    // Output patterns for the state being entered, with polarity applied.
    always_comb begin
        seg_al   = SEG_UNLIT_AL;
        seg_next = SEG_UNLIT;
        an_next  = AN_OFF;
        if (state_next == DRIVE) begin
            seg_al   = blank_sel ? SEG_UNLIT_AL : lut_seg_al;
            seg_next = (SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al;
            an_next  = (AN_ACTIVE_LOW != 0) ? ~an_en_sel : an_en_sel;
        end
    end

endmodule
